// File: rtl/branch_resolve_array.sv
// Multi-channel branch resolution: per-channel target, mispredict and exception evaluation
// with older-first kill, registered results and a resolution FIFO toward the frontend.
module branch_resolve_array #(
    parameter int unsigned NR_CH = 2,
    parameter int unsigned VLEN  = 64,
    parameter int unsigned DOM_W = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [DOM_W-1:0]       curdom_i,
    input  logic [NR_CH-1:0]       valid_i,
    output logic                   ready_o,
    input  logic [NR_CH-1:0]       op_branch_i,
    input  logic [NR_CH-1:0]       op_regjump_i,
    input  logic [NR_CH-1:0]       op_domchg_i,
    input  logic [NR_CH-1:0]       comp_res_i,
    input  logic [NR_CH-1:0]       compressed_i,
    input  logic [NR_CH*VLEN-1:0]  pc_i,
    input  logic [NR_CH*VLEN-1:0]  operand_a_i,
    input  logic [NR_CH*VLEN-1:0]  imm_i,
    input  logic [NR_CH*DOM_W-1:0] target_dom_i,
    input  logic [NR_CH*3-1:0]     pred_cf_i,
    input  logic [NR_CH*VLEN-1:0]  pred_addr_i,
    output logic [NR_CH-1:0]       result_valid_o,
    output logic [NR_CH*VLEN-1:0]  result_o,
    output logic [NR_CH-1:0]       ex_valid_o,
    output logic [NR_CH*VLEN-1:0]  ex_tval_o,
    output logic                   mispredict_o,
    output logic [VLEN-1:0]        redirect_pc_o,
    output logic [DOM_W-1:0]       redirect_dom_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [VLEN-1:0]        res_pc_o,
    output logic [VLEN-1:0]        res_target_o,
    output logic                   res_taken_o,
    output logic                   res_mispredict_o,
    output logic [2:0]             res_cf_o,
    output logic [DOM_W-1:0]       res_dom_o,
    output logic [31:0]            mispredict_cnt_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] CfNoCf   = 3'd0;
    localparam logic [2:0] CfBranch = 3'd1;
    localparam logic [2:0] CfJump   = 3'd2;
    localparam logic [2:0] CfJumpR  = 3'd3;
    localparam logic [2:0] CfReturn = 3'd4;

    logic [VLEN-1:0]  w_pc       [NR_CH];
    logic [VLEN-1:0]  w_base     [NR_CH];
    logic [VLEN-1:0]  w_tgt      [NR_CH];
    logic [VLEN-1:0]  w_next_pc  [NR_CH];
    logic [VLEN-1:0]  w_resolved [NR_CH];
    logic [2:0]       w_pcf      [NR_CH];
    logic [2:0]       w_cf       [NR_CH];
    logic [DOM_W-1:0] w_dom      [NR_CH];
    logic [AW-1:0]    w_idx      [NR_CH];
    logic [NR_CH-1:0] w_taken, w_mis, w_exc, w_alive, w_push;
    logic [CW-1:0]    w_push_cnt;
    logic             w_accept, w_killed, w_pop, w_mis_any;
    logic [VLEN-1:0]  w_redir_pc;
    logic [DOM_W-1:0] w_redir_dom;

    logic [VLEN-1:0]  r_f_pc     [DEPTH];
    logic [VLEN-1:0]  r_f_tgt    [DEPTH];
    logic [DEPTH-1:0] r_f_taken, r_f_mis;
    logic [2:0]       r_f_cf     [DEPTH];
    logic [DOM_W-1:0] r_f_dom    [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [NR_CH-1:0] r_res_valid, r_ex_valid;
    logic [VLEN-1:0]  r_result   [NR_CH];
    logic [VLEN-1:0]  r_tval     [NR_CH];
    logic             r_mis;
    logic [VLEN-1:0]  r_redir_pc;
    logic [DOM_W-1:0] r_redir_dom;
    logic [31:0]      r_mis_cnt;

    assign ready_o = (CW'(DEPTH) - r_count) >= CW'(NR_CH);
    assign w_pop   = res_valid_o & res_ready_i;

    always_comb begin
        w_accept    = ready_o & ~flush_i;
        w_killed    = 1'b0;
        w_push_cnt  = '0;
        w_mis_any   = 1'b0;
        w_redir_pc  = '0;
        w_redir_dom = '0;
        for (int ch = 0; ch < NR_CH; ch++) begin
            w_pc[ch]       = pc_i[ch*VLEN +: VLEN];
            w_pcf[ch]      = pred_cf_i[ch*3 +: 3];
            w_base[ch]     = op_regjump_i[ch] ? operand_a_i[ch*VLEN +: VLEN] : w_pc[ch];
            w_tgt[ch]      = (w_base[ch] + imm_i[ch*VLEN +: VLEN]) & ~(VLEN'(op_regjump_i[ch]));
            w_next_pc[ch]  = w_pc[ch] + (compressed_i[ch] ? VLEN'(2) : VLEN'(4));
            w_taken[ch]    = ~op_branch_i[ch] | comp_res_i[ch];
            w_resolved[ch] = w_taken[ch] ? w_tgt[ch] : w_next_pc[ch];
            w_mis[ch]      = 1'b0;
            w_cf[ch]       = CfJump;
            if (op_branch_i[ch]) begin
                w_mis[ch] = comp_res_i[ch] != (w_pcf[ch] == CfBranch);
                w_cf[ch]  = CfBranch;
            end else if (op_regjump_i[ch]) begin
                w_mis[ch] = (w_pcf[ch] == CfNoCf) | (w_tgt[ch] != pred_addr_i[ch*VLEN +: VLEN]);
                w_cf[ch]  = (w_pcf[ch] == CfReturn) ? CfReturn : CfJumpR;
            end
            w_dom[ch]   = (op_domchg_i[ch] & w_mis[ch]) ? target_dom_i[ch*DOM_W +: DOM_W]
                                                         : curdom_i;
            w_exc[ch]   = valid_i[ch] & w_taken[ch] & w_tgt[ch][0];
            w_alive[ch] = valid_i[ch] & w_accept & ~w_killed;
            w_push[ch]  = w_alive[ch] & ~w_exc[ch];
            w_idx[ch]   = r_wptr + w_push_cnt[AW-1:0];
            w_push_cnt  = w_push_cnt + CW'(w_push[ch]);
            // Only the kill point can be a surviving mispredict; younger channels die here.
            if (w_push[ch] & w_mis[ch]) begin
                w_mis_any   = 1'b1;
                w_redir_pc  = w_resolved[ch];
                w_redir_dom = w_dom[ch];
            end
            if (w_alive[ch] & (w_mis[ch] | w_exc[ch])) w_killed = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_res_valid <= '0;
            r_ex_valid  <= '0;
            r_mis       <= 1'b0;
            r_redir_pc  <= '0;
            r_redir_dom <= '0;
            r_f_taken   <= '0;
            r_f_mis     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_f_pc[i]  <= '0;
                r_f_tgt[i] <= '0;
                r_f_cf[i]  <= '0;
                r_f_dom[i] <= '0;
            end
            for (int ch = 0; ch < NR_CH; ch++) begin
                r_result[ch] <= '0;
                r_tval[ch]   <= '0;
            end
        end else if (flush_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_res_valid <= '0;
            r_ex_valid  <= '0;
            r_mis       <= 1'b0;
        end else begin
            r_res_valid <= w_alive & ~w_exc;
            r_ex_valid  <= w_alive & w_exc;
            r_mis       <= w_mis_any;
            if (w_mis_any) begin
                r_redir_pc  <= w_redir_pc;
                r_redir_dom <= w_redir_dom;
            end
            for (int ch = 0; ch < NR_CH; ch++) begin
                if (w_alive[ch]) begin
                    r_result[ch] <= w_next_pc[ch];
                    r_tval[ch]   <= w_pc[ch];
                end
                if (w_push[ch]) begin
                    r_f_pc[w_idx[ch]]    <= w_pc[ch];
                    r_f_tgt[w_idx[ch]]   <= w_resolved[ch];
                    r_f_taken[w_idx[ch]] <= w_taken[ch];
                    r_f_mis[w_idx[ch]]   <= w_mis[ch];
                    r_f_cf[w_idx[ch]]    <= w_cf[ch];
                    r_f_dom[w_idx[ch]]   <= w_dom[ch];
                end
            end
            r_wptr  <= r_wptr + w_push_cnt[AW-1:0];
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + w_push_cnt - CW'(w_pop);
        end
    end

    // Counts pulses already presented, so a flush arriving alongside one still counts it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mis_cnt <= '0;
        end else if (r_mis && (r_mis_cnt != '1)) begin
            r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end

    always_comb begin
        result_o  = '0;
        ex_tval_o = '0;
        for (int ch = 0; ch < NR_CH; ch++) begin
            result_o[ch*VLEN +: VLEN]  = r_result[ch];
            ex_tval_o[ch*VLEN +: VLEN] = r_tval[ch];
        end
    end

    assign result_valid_o   = r_res_valid;
    assign ex_valid_o       = r_ex_valid;
    assign mispredict_o     = r_mis;
    assign redirect_pc_o    = r_redir_pc;
    assign redirect_dom_o   = r_redir_dom;
    assign mispredict_cnt_o = r_mis_cnt;
    assign res_valid_o      = r_count != '0;
    assign res_pc_o         = r_f_pc[r_rptr];
    assign res_target_o     = r_f_tgt[r_rptr];
    assign res_taken_o      = r_f_taken[r_rptr];
    assign res_mispredict_o = r_f_mis[r_rptr];
    assign res_cf_o         = r_f_cf[r_rptr];
    assign res_dom_o        = r_f_dom[r_rptr];
endmodule
